// File: rtl/cmos_pkg.sv
// cmos_pkg: shared types and constants for the CMOS sensor power sequencer.
//   seq_state_t   - sequencer state encoding (3 bits)
//   seq_out_t     - bundle of the four level outputs driven per state
//   DEF_*         - default cycle counts for a 50 MHz clock
//   LOCK_LOSS_W   - width of the saturating lock-loss counter
//   state_outputs - per-state output decode
//   sat_inc       - saturating increment for the lock-loss counter
package cmos_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_PWDN      = 3'd1,
    S_XCLK      = 3'd2,
    S_SETTLE    = 3'd3,
    S_READY     = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic pwdn;
    logic rst_n;
    logic xclk_en;
    logic ready;
  } seq_out_t;

  localparam int DEF_LOCK_STABLE_CYC = 1024;
  localparam int DEF_PWDN_CYC        = 50000;
  localparam int DEF_RST_CYC         = 50000;
  localparam int DEF_SETTLE_CYC      = 1000000;
  localparam int DEF_CNT_W           = 21;
  localparam int LOCK_LOSS_W         = 8;

  // Output levels for each state; anything unexpected maps to the safe
  // (powered-down, in-reset, clock-off) levels.
  function automatic seq_out_t state_outputs(input seq_state_t st);
    seq_out_t o;
    case (st)
      S_WAIT_LOCK: o = '{pwdn: 1'b1, rst_n: 1'b0, xclk_en: 1'b0, ready: 1'b0};
      S_PWDN:      o = '{pwdn: 1'b1, rst_n: 1'b0, xclk_en: 1'b0, ready: 1'b0};
      S_XCLK:      o = '{pwdn: 1'b0, rst_n: 1'b0, xclk_en: 1'b1, ready: 1'b0};
      S_SETTLE:    o = '{pwdn: 1'b0, rst_n: 1'b1, xclk_en: 1'b1, ready: 1'b0};
      S_READY:     o = '{pwdn: 1'b0, rst_n: 1'b1, xclk_en: 1'b1, ready: 1'b1};
      default:     o = '{pwdn: 1'b1, rst_n: 1'b0, xclk_en: 1'b0, ready: 1'b0};
    endcase
    return o;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LOCK_LOSS_W-1:0] sat_inc(input logic [LOCK_LOSS_W-1:0] v);
    logic [LOCK_LOSS_W-1:0] r;
    if (v == {LOCK_LOSS_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(LOCK_LOSS_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, asynchronous reset to 0.
//   clk - destination clock
//   rst - asynchronous active-high reset
//   d   - asynchronous input
//   q   - synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmos_power_seq.sv
// cmos_power_seq: CMOS sensor power-up sequencer driven by camera PLL lock.
// Waits for a stable lock, then walks power-down -> XCLK on with sensor reset
// held -> reset released and settling -> ready. Lock loss drops back to the
// safe state and is counted; restart reruns the sequence from power-down.
//   clkin         - 50 MHz system clock
//   reset         - asynchronous active-high reset
//   pll_lock      - PLL lock, asynchronous to clkin
//   restart       - one-cycle request to rerun the sequence
//   cmos_pwdn     - sensor power-down (1 = powered down)
//   cmos_rst_n    - sensor reset, active-low
//   xclk_en       - enable for the sensor XCLK clock buffer
//   cam_ready     - sequence complete
//   init_start    - one-cycle pulse on entry to S_READY
//   lock_loss_cnt - saturating count of lock losses after lock-stable point
module cmos_power_seq
  import cmos_pkg::*;
#(
  parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int PWDN_CYC        = DEF_PWDN_CYC,
  parameter int RST_CYC         = DEF_RST_CYC,
  parameter int SETTLE_CYC      = DEF_SETTLE_CYC,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   pll_lock,
  input  logic                   restart,
  output logic                   cmos_pwdn,
  output logic                   cmos_rst_n,
  output logic                   xclk_en,
  output logic                   cam_ready,
  output logic                   init_start,
  output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

  localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

  // Reject parameter sets the dwell counter cannot represent.
  if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
    $error("cmos_power_seq: CNT_W out of range");
  end
  if (LOCK_STABLE_CYC < 1 || PWDN_CYC < 1 || RST_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_cyc
    $error("cmos_power_seq: every *_CYC parameter must be >= 1");
  end
  if (longint'(LOCK_STABLE_CYC) > CNT_MAX || longint'(PWDN_CYC) > CNT_MAX ||
      longint'(RST_CYC) > CNT_MAX || longint'(SETTLE_CYC) > CNT_MAX) begin : g_bad_width
    $error("cmos_power_seq: CNT_W too narrow for the largest *_CYC");
  end

  // Terminal counter values: the counter runs 0..N-1 and the move happens at N-1.
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic                   lock_s;
  seq_state_t             state;
  seq_state_t             state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [LOCK_LOSS_W-1:0] loss_nxt;
  logic [CNT_W-1:0]       dwell_last;
  seq_state_t             dwell_next;
  seq_out_t               out_nxt;

  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Dwell length and successor for the timed states.
  always_comb begin
    dwell_last = '0;
    dwell_next = S_WAIT_LOCK;
    case (state)
      S_PWDN: begin
        dwell_last = PWDN_LAST;
        dwell_next = S_XCLK;
      end
      S_XCLK: begin
        dwell_last = RST_LAST;
        dwell_next = S_SETTLE;
      end
      S_SETTLE: begin
        dwell_last = SETTLE_LAST;
        dwell_next = S_READY;
      end
      default: begin
        dwell_last = '0;
        dwell_next = S_WAIT_LOCK;
      end
    endcase
  end

  // Next-state, dwell counter and loss counter. Priority outside S_WAIT_LOCK:
  // lock loss, then restart, then normal dwell progression.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_nxt  = lock_loss_cnt;
    if (state == S_WAIT_LOCK) begin
      if (!lock_s) begin
        cnt_nxt = '0;
      end else if (cnt == LOCK_LAST) begin
        state_nxt = S_PWDN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end else if (!lock_s) begin
      state_nxt = S_WAIT_LOCK;
      cnt_nxt   = '0;
      loss_nxt  = sat_inc(lock_loss_cnt);
    end else if (restart) begin
      state_nxt = S_PWDN;
      cnt_nxt   = '0;
    end else if (state == S_READY) begin
      state_nxt = S_READY;
      cnt_nxt   = '0;
    end else if (state == S_PWDN || state == S_XCLK || state == S_SETTLE) begin
      if (cnt == dwell_last) begin
        state_nxt = dwell_next;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end else begin
      // Illegal encoding: fall back to the safe state.
      state_nxt = S_WAIT_LOCK;
      cnt_nxt   = '0;
    end
  end

  // Decode outputs from the next state so they change on the entering edge.
  always_comb begin
    out_nxt = state_outputs(state_nxt);
  end

  // Sequencer registers and registered outputs.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state         <= S_WAIT_LOCK;
      cnt           <= '0;
      lock_loss_cnt <= '0;
      cmos_pwdn     <= 1'b1;
      cmos_rst_n    <= 1'b0;
      xclk_en       <= 1'b0;
      cam_ready     <= 1'b0;
      init_start    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      lock_loss_cnt <= loss_nxt;
      cmos_pwdn     <= out_nxt.pwdn;
      cmos_rst_n    <= out_nxt.rst_n;
      xclk_en       <= out_nxt.xclk_en;
      cam_ready     <= out_nxt.ready;
      // Pulse only on the edge that enters S_READY, not while staying there.
      init_start    <= (state_nxt == S_READY) && (state != S_READY);
    end
  end

endmodule

// File: tb/tb_cmos_power_seq.sv
// tb_cmos_power_seq: table-driven and directed checks of cmos_power_seq with
// small cycle counts (lock 4, pwdn 3, rst 5, settle 7).
// Inputs change and outputs are sampled at the falling edge of clkin.
// Output bundle order in expectations: {pwdn, rst_n, xclk_en, ready, init_start}.
module tb_cmos_power_seq;

  logic       clkin;
  logic       reset;
  logic       pll_lock;
  logic       restart;
  logic       cmos_pwdn;
  logic       cmos_rst_n;
  logic       xclk_en;
  logic       cam_ready;
  logic       init_start;
  logic [7:0] lock_loss_cnt;

  int vectors;
  int misses;
  int init_count;

  typedef struct {
    logic       lock;
    logic       rst_req;
    logic [4:0] exp;
    logic [7:0] loss;
  } vec_t;

  vec_t tbl [24];

  cmos_power_seq #(
    .LOCK_STABLE_CYC (4),
    .PWDN_CYC        (3),
    .RST_CYC         (5),
    .SETTLE_CYC      (7),
    .CNT_W           (4)
  ) dut (
    .clkin         (clkin),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .restart       (restart),
    .cmos_pwdn     (cmos_pwdn),
    .cmos_rst_n    (cmos_rst_n),
    .xclk_en       (xclk_en),
    .cam_ready     (cam_ready),
    .init_start    (init_start),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Count init_start pulses as seen at the sampling edge.
  always @(negedge clkin) begin
    if (init_start === 1'b1) init_count <= init_count + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clkin);
  endtask

  task automatic chk(input string name, input logic [4:0] exp, input logic [7:0] el);
    logic [4:0] got;
    got = {cmos_pwdn, cmos_rst_n, xclk_en, cam_ready, init_start};
    vectors++;
    if (got !== exp || lock_loss_cnt !== el) begin
      misses++;
      $display("FAIL %s: got outs=%b loss=%0d, expected outs=%b loss=%0d",
               name, got, lock_loss_cnt, exp, el);
    end
  endtask

  task automatic wait_check(input int n, input string name, input logic [4:0] exp,
                            input logic [7:0] el);
    tick(n);
    chk(name, exp, el);
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      misses++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // From S_WAIT_LOCK with the synchronizer holding 0: raise lock and follow
  // the full sequence, expecting exactly one init_start pulse.
  task automatic relock(input logic [7:0] el);
    int n0;
    n0 = init_count;
    pll_lock = 1'b1;
    wait_check(8, "relock_pwdn_hold",   5'b10000, el);
    wait_check(1, "relock_xclk",        5'b00100, el);
    wait_check(5, "relock_settle",      5'b01100, el);
    wait_check(6, "relock_settle_end",  5'b01100, el);
    wait_check(1, "relock_ready",       5'b01111, el);
    wait_check(1, "relock_ready_hold",  5'b01110, el);
    wait_check(10, "relock_ready_late", 5'b01110, el);
    #1;
    chk_int("relock_init_pulses", init_count - n0, 1);
  endtask

  initial begin
    vectors    = 0;
    misses     = 0;
    init_count = 0;
    reset      = 1'b1;
    pll_lock   = 1'b0;
    restart    = 1'b0;

    // Nominal power-up; entry i is checked after edge E(i+1) following the
    // first lock edge. A restart in S_WAIT_LOCK (entry 2) must be ignored.
    tbl[0]  = '{1'b1, 1'b0, 5'b10000, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 5'b10000, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 5'b10000, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 5'b10000, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 5'b10000, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 5'b10000, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 5'b10000, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 5'b10000, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 5'b00100, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 5'b00100, 8'd0};
    tbl[10] = '{1'b1, 1'b0, 5'b00100, 8'd0};
    tbl[11] = '{1'b1, 1'b0, 5'b00100, 8'd0};
    tbl[12] = '{1'b1, 1'b0, 5'b00100, 8'd0};
    tbl[13] = '{1'b1, 1'b0, 5'b01100, 8'd0};
    tbl[14] = '{1'b1, 1'b0, 5'b01100, 8'd0};
    tbl[15] = '{1'b1, 1'b0, 5'b01100, 8'd0};
    tbl[16] = '{1'b1, 1'b0, 5'b01100, 8'd0};
    tbl[17] = '{1'b1, 1'b0, 5'b01100, 8'd0};
    tbl[18] = '{1'b1, 1'b0, 5'b01100, 8'd0};
    tbl[19] = '{1'b1, 1'b0, 5'b01100, 8'd0};
    tbl[20] = '{1'b1, 1'b0, 5'b01111, 8'd0};
    tbl[21] = '{1'b1, 1'b0, 5'b01110, 8'd0};
    tbl[22] = '{1'b1, 1'b0, 5'b01110, 8'd0};
    tbl[23] = '{1'b1, 1'b0, 5'b01110, 8'd0};

    tick(3);
    chk("reset_state", 5'b10000, 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      pll_lock = tbl[i].lock;
      restart  = tbl[i].rst_req;
      tick(1);
      chk($sformatf("nominal_e%0d", i + 1), tbl[i].exp, tbl[i].loss);
    end
    restart = 1'b0;

    // Restart pulse in S_READY: back to power-down, sequence 3+5+7.
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("restart_pwdn", 5'b10000, 8'd0);
    wait_check(2, "restart_pwdn_end",   5'b10000, 8'd0);
    wait_check(1, "restart_xclk",       5'b00100, 8'd0);
    wait_check(4, "restart_xclk_end",   5'b00100, 8'd0);
    wait_check(1, "restart_settle",     5'b01100, 8'd0);
    wait_check(6, "restart_settle_end", 5'b01100, 8'd0);
    wait_check(1, "restart_ready",      5'b01111, 8'd0);
    wait_check(1, "restart_ready_hold", 5'b01110, 8'd0);

    // Lock loss and restart on the same edge: lock loss wins.
    pll_lock = 1'b0;
    wait_check(2, "both_sync_delay", 5'b01110, 8'd0);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("both_loss_wins", 5'b10000, 8'd1);
    relock(8'd1);

    // Lock loss at settle cycle 3.
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("settle_restart", 5'b10000, 8'd1);
    wait_check(11, "settle_cycle3", 5'b01100, 8'd1);
    pll_lock = 1'b0;
    wait_check(2, "settle_sync_delay", 5'b01100, 8'd1);
    wait_check(1, "settle_loss",       5'b10000, 8'd2);
    relock(8'd2);

    // Async reset between clock edges while in S_XCLK.
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("pre_reset_pwdn", 5'b10000, 8'd2);
    wait_check(4, "pre_reset_xclk", 5'b00100, 8'd2);
    #2;
    reset    = 1'b1;
    pll_lock = 1'b0;
    #1;
    chk("async_reset_mid_xclk", 5'b10000, 8'd0);
    tick(2);
    reset = 1'b0;

    // Lock bounce during stabilization: 3 high, 1 low, then high.
    pll_lock = 1'b1;
    tick(3);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_check(8, "bounce_still_pwdn", 5'b10000, 8'd0);
    wait_check(1, "bounce_xclk",       5'b00100, 8'd0);

    // Saturation: repeated losses from S_PWDN.
    reset = 1'b1;
    tick(1);
    reset    = 1'b0;
    pll_lock = 1'b0;
    tick(2);
    for (int i = 0; i < 260; i++) begin
      pll_lock = 1'b1;
      tick(6);
      pll_lock = 1'b0;
      wait_check(3, $sformatf("sat_loss_%0d", i + 1), 5'b10000,
                 (i + 1 > 255) ? 8'd255 : 8'(i + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
